quiz_countdown_ctrl: RTL

- Upstream stage of the dynamic-scan display: arbitrates four contestant buttons, runs the answer countdown and flags fouls (early presses).
- Its packed 10-bit display word and foul flag feed the scan-display block's DataIn and ErrorFlag inputs directly.
- Sits between the synchronised panel inputs and the display path, on the same 50 MHz clock.

---
 rtl/quiz_pkg.sv | 52 +++++
 rtl/tick_gen.sv | 31 +++
 rtl/quiz_countdown_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// Shared state encoding, display-word layout and BCD helpers for quiz_countdown_ctrl.
package quiz_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_LOCK    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_FOUL    = 3'd4
  } state_t;

  localparam int NUM_PLAYERS = 4;
  localparam int WINNER_MSB  = 9;
  localparam int TENS_LSB    = 4;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } secs_t;

  // Two-digit BCD decrement that saturates at 00.
  function automatic secs_t secs_dec(input secs_t s);
    secs_t r;
    r = s;
    if (s.units != 4'd0) begin
      r.units = s.units - 4'd1;
    end else if (s.tens != 4'd0) begin
      r.tens  = s.tens - 4'd1;
      r.units = 4'd9;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Lowest asserted index wins; returns 0 when nothing is set.
  function automatic logic [1:0] first_idx(input logic [NUM_PLAYERS-1:0] e);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (e[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV divider with synchronous clear; tick is high for the last count of each period.
module tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Period counter, parked at zero while cleared so the first period after release is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = !clr && (cnt_r == LAST);

endmodule

// File: rtl/quiz_countdown_ctrl.sv
// Quiz arbiter: button priority, BCD answer countdown and foul detection feeding the scan display.
// Optional buzzer sequencer enabled by defining BUZZER_EN.
import quiz_pkg::*;

module quiz_countdown_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int INIT_SEC    = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       host_start,
  input  logic       host_clear,
  input  logic [3:0] btn,
  output logic [9:0] data_out,
  output logic       error_flag,
  output logic       busy,
  output logic       beep
);

  localparam int    TICK_DIV  = CLK_HZ / TICK_HZ;
  localparam int    IN_W      = NUM_PLAYERS + 2;
  localparam secs_t SECS_INIT = {4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};

  logic [IN_W-1:0]        sync_r [SYNC_STAGES];
  logic [IN_W-1:0]        prev_r;
  logic [IN_W-1:0]        rise_s;
  logic [NUM_PLAYERS-1:0] btn_rise_s;
  logic                   start_rise_s;
  logic                   clear_rise_s;

  state_t     state_r, state_nxt_s;
  secs_t      secs_r, secs_nxt_s;
  logic [1:0] winner_r, winner_nxt_s;
  logic       tick_s;
  logic       tick_clr_s;

  logic [9:0] data_out_r;
  logic       error_flag_r;
  logic       busy_r;

  // Synchroniser chain for all panel inputs plus one delay stage for edge detection.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= {host_clear, host_start, btn};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_s       = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign btn_rise_s   = rise_s[NUM_PLAYERS-1:0];
  assign start_rise_s = rise_s[NUM_PLAYERS];
  assign clear_rise_s = rise_s[NUM_PLAYERS+1];

  // Held clear outside COUNT so the first decrement lands a full period after start.
  assign tick_clr_s = (state_r != S_COUNT);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_sec_tick (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .clr   (tick_clr_s),
    .tick  (tick_s)
  );

  // State, remaining seconds and winner registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      secs_r   <= '0;
      winner_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      secs_r   <= secs_nxt_s;
      winner_r <= winner_nxt_s;
    end
  end

  // Next-state logic; host_clear beats every other event, a press beats a coincident tick.
  always_comb begin
    state_nxt_s  = state_r;
    secs_nxt_s   = secs_r;
    winner_nxt_s = winner_r;
    if (clear_rise_s) begin
      state_nxt_s  = S_IDLE;
      secs_nxt_s   = '0;
      winner_nxt_s = 2'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_rise_s) begin
            state_nxt_s  = S_COUNT;
            secs_nxt_s   = SECS_INIT;
            winner_nxt_s = 2'd0;
          end else if (|btn_rise_s) begin
            state_nxt_s  = S_FOUL;
            winner_nxt_s = first_idx(btn_rise_s);
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_COUNT: begin
          if (|btn_rise_s) begin
            state_nxt_s  = S_LOCK;
            winner_nxt_s = first_idx(btn_rise_s);
          end else if (tick_s) begin
            secs_nxt_s = secs_dec(secs_r);
            if (secs_nxt_s == '0) begin
              state_nxt_s = S_TIMEOUT;
            end else begin
              state_nxt_s = S_COUNT;
            end
          end else begin
            state_nxt_s = S_COUNT;
          end
        end
        S_LOCK, S_TIMEOUT, S_FOUL: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s  = S_IDLE;
          secs_nxt_s   = '0;
          winner_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // Display word and flags follow the state registers by one cycle.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= 10'h000;
      error_flag_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_out_r[WINNER_MSB -: 2]  <= winner_r;
      data_out_r[TENS_LSB +: 4]    <= secs_r.tens;
      data_out_r[TENS_LSB-1:0]     <= secs_r.units;
      error_flag_r                 <= (state_r == S_FOUL);
      busy_r                       <= (state_r == S_COUNT);
    end
  end

  assign data_out   = data_out_r;
  assign error_flag = error_flag_r;
  assign busy       = busy_r;

`ifdef BUZZER_EN
  typedef enum logic [1:0] {
    BZ_OFF    = 2'd0,
    BZ_STEADY = 2'd1,
    BZ_TOGGLE = 2'd2
  } bz_mode_t;

  localparam int EIGHTH_DIV = CLK_HZ / 8;

  bz_mode_t   bz_mode_r;
  logic [3:0] bz_cnt_r;
  logic       beep_r;
  logic       bz_tick_s;
  logic       bz_clr_s;
  logic       lock_entry_s;
  logic       alarm_entry_s;

  assign lock_entry_s  = (state_nxt_s == S_LOCK) && (state_r != S_LOCK);
  assign alarm_entry_s = ((state_nxt_s == S_FOUL) && (state_r != S_FOUL)) ||
                         ((state_nxt_s == S_TIMEOUT) && (state_r != S_TIMEOUT));
  assign bz_clr_s      = lock_entry_s || alarm_entry_s || clear_rise_s || (bz_mode_r == BZ_OFF);

  tick_gen #(
    .DIV (EIGHTH_DIV)
  ) u_bz_tick (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .clr   (bz_clr_s),
    .tick  (bz_tick_s)
  );

  // Buzzer sequencer in 1/8 s steps: 4 steps steady for LOCK, 8 alternating steps for FOUL/TIMEOUT.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      bz_mode_r <= BZ_OFF;
      bz_cnt_r  <= 4'd0;
      beep_r    <= 1'b0;
    end else if (clear_rise_s) begin
      bz_mode_r <= BZ_OFF;
      bz_cnt_r  <= 4'd0;
      beep_r    <= 1'b0;
    end else if (lock_entry_s) begin
      bz_mode_r <= BZ_STEADY;
      bz_cnt_r  <= 4'd0;
      beep_r    <= 1'b1;
    end else if (alarm_entry_s) begin
      bz_mode_r <= BZ_TOGGLE;
      bz_cnt_r  <= 4'd0;
      beep_r    <= 1'b1;
    end else if (bz_tick_s) begin
      case (bz_mode_r)
        BZ_STEADY: begin
          if (bz_cnt_r == 4'd3) begin
            bz_mode_r <= BZ_OFF;
            beep_r    <= 1'b0;
          end else begin
            bz_cnt_r <= bz_cnt_r + 4'd1;
          end
        end
        BZ_TOGGLE: begin
          if (bz_cnt_r == 4'd7) begin
            bz_mode_r <= BZ_OFF;
            beep_r    <= 1'b0;
          end else begin
            bz_cnt_r <= bz_cnt_r + 4'd1;
            beep_r   <= ~beep_r;
          end
        end
        default: begin
          bz_mode_r <= BZ_OFF;
          beep_r    <= 1'b0;
        end
      endcase
    end else begin
      bz_mode_r <= bz_mode_r;
    end
  end

  assign beep = beep_r;
`else
  assign beep = 1'b0;
`endif

endmodule
